// File: rtl/mem_arb_pkg.sv
// Shared types and parameter limits for the unified-memory port arbiter.
package mem_arb_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    RD_WAIT = 1'b1
  } arb_state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  localparam int RD_LAT_MIN     = 1;
  localparam int RD_LAT_MAX     = 4;
  localparam int STARVE_MAX_MIN = 1;
  localparam int STARVE_MAX_LIM = 15;

  // Latency counter holds RD_LAT-1; starvation counter reaches STARVE_MAX.
  localparam int LAT_CNT_W    = $clog2(RD_LAT_MAX);
  localparam int STARVE_CNT_W = $clog2(STARVE_MAX_LIM + 1);

endpackage

// File: rtl/mem_arb_starve_cnt.sv
// Saturating count of consecutive arbitrations fetch lost to data;
// force_i tells the arbiter to hand the next grantable cycle to fetch.
module mem_arb_starve_cnt
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_req,
  input  logic i_gnt,
  input  logic d_gnt,
  output logic force_i
);

  localparam logic [STARVE_CNT_W-1:0] LIMIT = STARVE_CNT_W'(STARVE_MAX);

  logic [STARVE_CNT_W-1:0] count;

  // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (!i_req || i_gnt) begin
      count <= '0;
    end else if (d_gnt && (count != LIMIT)) begin
      count <= count + 1'b1;
    end
  end

  assign force_i = (count == LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and load/store:
// data wins by default, fetch is forced through after STARVE_MAX losses.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 32,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic                CLK,
  input  logic                RSTn,
  input  logic                I_REQ,
  input  logic [ADDR_W-1:0]   I_ADDR,
  output logic                I_GNT,
  output logic                I_RVALID,
  output logic [DATA_W-1:0]   I_RDATA,
  input  logic                D_REQ,
  input  logic                D_WE,
  input  logic [ADDR_W-1:0]   D_ADDR,
  input  logic [DATA_W/8-1:0] D_BE,
  input  logic [DATA_W-1:0]   D_WDATA,
  output logic                D_GNT,
  output logic                D_RVALID,
  output logic [DATA_W-1:0]   D_RDATA,
  output logic                M_CSN,
  output logic                M_WEN,
  output logic [DATA_W/8-1:0] M_BE,
  output logic [ADDR_W-1:0]   M_ADDR,
  output logic [DATA_W-1:0]   M_WDATA,
  input  logic [DATA_W-1:0]   M_RDATA,
  output logic                BUSY
);

  arb_state_e             state, state_nxt;
  logic [LAT_CNT_W-1:0]   lat_cnt, lat_cnt_nxt;
  owner_e                 rd_owner, rd_owner_nxt;
  logic                   ret_valid, ret_valid_nxt;

  logic grantable;
  logic force_i;
  logic i_win;
  logic d_win;
  logic rd_grant;

  assign grantable = (state == IDLE);
  assign d_win     = grantable && D_REQ && !(force_i && I_REQ);
  assign i_win     = grantable && I_REQ && !d_win;
  assign rd_grant  = i_win || (d_win && !D_WE);

  mem_arb_starve_cnt #(
    .STARVE_MAX(STARVE_MAX)
  ) u_starve (
    .clk    (CLK),
    .rst_n  (RSTn),
    .i_req  (I_REQ),
    .i_gnt  (i_win),
    .d_gnt  (d_win),
    .force_i(force_i)
  );

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state     <= IDLE;
      lat_cnt   <= '0;
      rd_owner  <= OWN_I;
      ret_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      lat_cnt   <= lat_cnt_nxt;
      rd_owner  <= rd_owner_nxt;
      ret_valid <= ret_valid_nxt;
    end
  end

  // ret_valid marks the cycle the memory presents data; with RD_LAT=1 it
  // follows the grant directly and the FSM never leaves IDLE.
  // NOTE: every always_comb output gets a default first; a missed branch would otherwise infer a latch.
  always_comb begin
    state_nxt     = state;
    lat_cnt_nxt   = lat_cnt;
    rd_owner_nxt  = rd_owner;
    ret_valid_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (rd_grant) begin
          rd_owner_nxt = i_win ? OWN_I : OWN_D;
          if (RD_LAT == 1) begin
            ret_valid_nxt = 1'b1;
          end else begin
            state_nxt   = RD_WAIT;
            lat_cnt_nxt = LAT_CNT_W'(RD_LAT - 1);
          end
        end
      end
      RD_WAIT: begin
        if (lat_cnt == LAT_CNT_W'(1)) begin
          state_nxt     = IDLE;
          ret_valid_nxt = 1'b1;
        end else begin
          lat_cnt_nxt = lat_cnt - 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    M_CSN   = 1'b1;
    M_WEN   = 1'b1;
    M_BE    = '0;
    M_ADDR  = '0;
    M_WDATA = '0;
    if (d_win) begin
      M_CSN   = 1'b0;
      M_WEN   = !D_WE;
      M_BE    = D_WE ? D_BE : '1;
      M_ADDR  = D_ADDR;
      M_WDATA = D_WDATA;
    end else if (i_win) begin
      M_CSN  = 1'b0;
      M_BE   = '1;
      M_ADDR = I_ADDR;
    end
  end

  assign I_GNT    = i_win;
  assign D_GNT    = d_win;
  assign I_RVALID = ret_valid && (rd_owner == OWN_I);
  assign D_RVALID = ret_valid && (rd_owner == OWN_D);
  assign I_RDATA  = I_RVALID ? M_RDATA : '0;
  assign D_RDATA  = D_RVALID ? M_RDATA : '0;
  assign BUSY     = (state == RD_WAIT);

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbiter and sequencer that shares a single-ported unified memory between the multicycle core's instruction-fetch path and its load/store path. It serialises requests from both sides, drives the memory's active-low chip-select and write-enable, and returns read data with a fixed-latency valid strobe. Data accesses win by default, with a bounded-wait guarantee for fetch.

## Interface
- ADDR_W, 12, word address width
- DATA_W, 32, data width; BE width is DATA_W/8
- RD_LAT, 1, memory read latency in cycles; legal 1..4
- STARVE_MAX, 4, consecutive lost arbitrations before fetch is forced to win; legal 1..15

- CLK  in  1  clock, all state on rising edge
- RSTn  in  1  reset, asynchronous, active-low
- I_REQ  in  1  fetch request, held until I_GNT
- I_ADDR  in  ADDR_W  fetch address, stable while I_REQ
- I_GNT  out  1  one-cycle grant pulse
- I_RVALID  out  1  one-cycle fetch data valid
- I_RDATA  out  DATA_W  fetch data, meaningful only with I_RVALID
- D_REQ  in  1  data request, held until D_GNT
- D_WE  in  1  1 = store, 0 = load
- D_ADDR  in  ADDR_W  data address
- D_BE  in  DATA_W/8  store byte enables
- D_WDATA  in  DATA_W  store data
- D_GNT  out  1  one-cycle grant pulse
- D_RVALID  out  1  one-cycle load data valid
- D_RDATA  out  DATA_W  load data
- M_CSN  out  1  memory chip select, active-low
- M_WEN  out  1  memory write enable, active-low (0 = write)
- M_BE  out  DATA_W/8  memory byte enables
- M_ADDR  out  ADDR_W  memory address
- M_WDATA  out  DATA_W  memory write data
- M_RDATA  in  DATA_W  memory read data, valid RD_LAT cycles after access
- BUSY  out  1  read outstanding

## Operation
- FSM states: IDLE (may grant), RD_WAIT (read outstanding, latency counter running).
- Grant cycle t: owner's GNT=1, M_CSN=0, M_ADDR/M_WDATA/M_WEN/M_BE driven combinationally from the winner's inputs.
- Store: M_WEN=0, M_BE=D_BE; completes at t, no RVALID; FSM stays IDLE, next grant legal at t+1.
- Load/fetch: M_WEN=1, M_BE all-ones; FSM enters RD_WAIT, latency counter loads RD_LAT-1 (RD_LAT=1: no RD_WAIT cycle).
- Return at t+RD_LAT: owner's RVALID=1, xRDATA=M_RDATA; FSM is IDLE in this cycle and may issue a new grant here (back-to-back reads every RD_LAT cycles).
- Priority: D beats I unless starvation count == STARVE_MAX, then I wins.
- Starvation count: increments each grantable cycle with I_REQ=1 and D granted; clears on I grant or I_REQ=0; saturates at STARVE_MAX.
- Request withdrawn before grant: permitted; no access, count clears if I_REQ drops.
- D_WE=1 with D_BE=0: granted, memory cycle issued with M_BE=0.
- Idle (no grant): M_CSN=1, M_WEN=1, M_BE=0, M_ADDR/M_WDATA=0.

## Timing
- Reset values: all GNT/RVALID=0, xRDATA=0, M_CSN=1, M_WEN=1, M_BE=0, M_ADDR=0, M_WDATA=0, BUSY=0, FSM=IDLE, counters=0.
- Reset mid-read: outstanding read discarded, no RVALID after release.
- Grant-to-memory latency 0 cycles; grant-to-RVALID exactly RD_LAT cycles.
- BUSY=1 from t+1 through t+RD_LAT-1 for reads; never for stores.
- No grant while BUSY=1.

## Structure
- Package mem_arb_pkg: state enum (IDLE, RD_WAIT), owner encoding (OWN_I, OWN_D), RD_LAT/STARVE_MAX legal-range constants.
- Sub-module mem_arb_starve_cnt: saturating starvation counter with force-I output.
- Read-owner register and latency counter live in the top.

## Test plan
- Reset mid-read (RD_LAT=3, assert RSTn=0 at t+1) -> no RVALID ever; all outputs at reset values immediately.
- I_REQ alone, addr 0x010, RD_LAT=2, M_RDATA=0xDEADBEEF at t+2 -> I_GNT at t, M_CSN=0, M_WEN=1, I_RVALID with 0xDEADBEEF at t+2.
- Both request, D store to 0x020 BE=0011 data 0x12345678 -> D_GNT, M_WEN=0, M_BE=0011 at t; I_GNT at t+1.
- D_REQ held continuously with I_REQ, STARVE_MAX=4, stores -> four D grants, fifth grant to I, count cleared.
- Back-to-back D loads RD_LAT=1 -> one grant per cycle, D_RVALID each following cycle, BUSY stays 0.
- I_REQ withdrawn before grant during a D read -> no I access, starvation count returns to 0.
